// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte producers.
// Generates the baud tick, drives the transmitter's data/valid and holds each byte for its whole frame.
module uart_tx_scheduler #(
  parameter int N_REQ    = 4,
  parameter int BAUD_DIV = 16
) (
  input  logic               CLKIN,
  input  logic               RESET,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic               busy,
  output logic               clock_enable,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready
);

  localparam int              LW       = $clog2(N_REQ);
  localparam logic [15:0]     DIV_MAX  = 16'(BAUD_DIV - 1);
  localparam logic [LW-1:0]   LAST_RST = LW'(N_REQ - 1);
  localparam logic [LW:0]     N_WIDE   = (LW+1)'(N_REQ);

  typedef enum logic [1:0] {FLUSH, IDLE, REQ, HOLD} state_t;

  state_t           state_q, state_d;
  logic [15:0]      div_cnt_q, div_cnt_d;
  logic             ce_q, ce_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic [3:0]       hold_cnt_q, hold_cnt_d;
  logic [LW-1:0]    last_q, last_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;

  logic             win_vld;
  logic [LW-1:0]    win_idx;
  logic [LW:0]      rr_sum;

  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_MAX) ? 16'd0 : div_cnt_q + 16'd1;
    ce_d      = (div_cnt_q == DIV_MAX);
  end

  // First requester at or after last+1, wrapping; last+i never exceeds 2*N_REQ-1.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    rr_sum  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      rr_sum = {1'b0, last_q} + (LW+1)'(i);
      if (rr_sum >= N_WIDE) rr_sum = rr_sum - N_WIDE;
      if (!win_vld && req[rr_sum[LW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = rr_sum[LW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    last_d      = last_q;
    grant_d     = '0;
    done_d      = '0;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    case (state_q)
      FLUSH: begin
        if (ce_q) begin
          if (flush_cnt_q == 4'd10) begin
            flush_cnt_d = 4'd0;
            state_d     = IDLE;
          end else begin
            flush_cnt_d = flush_cnt_q + 4'd1;
          end
        end
      end
      IDLE: begin
        tx_valid_d = 1'b0;
        if (win_vld) begin
          tx_data_d        = req_data[{win_idx, 3'b000} +: 8];
          grant_d[win_idx] = 1'b1;
          tx_valid_d       = 1'b1;
          last_d           = win_idx;
          state_d          = REQ;
        end
      end
      REQ: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          hold_cnt_d = 4'd10;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        // Start, eight data bits and stop: the next valid lands on the post-stop tick.
        if (ce_q) begin
          hold_cnt_d = hold_cnt_q - 4'd1;
          if (hold_cnt_q == 4'd1) begin
            done_d[last_q] = 1'b1;
            state_d        = IDLE;
          end
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      state_q     <= FLUSH;
      div_cnt_q   <= 16'd0;
      ce_q        <= 1'b0;
      flush_cnt_q <= 4'd0;
      hold_cnt_q  <= 4'd0;
      last_q      <= LAST_RST;
      grant_q     <= '0;
      done_q      <= '0;
      tx_data_q   <= 8'hFF;
      tx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      ce_q        <= ce_d;
      flush_cnt_q <= flush_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
    end
  end

  assign grant        = grant_q;
  assign done         = done_q;
  assign busy         = (state_q != IDLE);
  assign clock_enable = ce_q;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench: a BAUD_DIV=4 scheduler driving a behavioural transmitter, plus a BAUD_DIV=1 instance.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   grant, done;
  logic           busy, ce, tx_valid;
  logic [7:0]     tx_data;
  logic           tx_ready = 1'b0;

  uart_tx_scheduler #(.N_REQ(N), .BAUD_DIV(4)) dut (
    .CLKIN(clk), .RESET(rst), .req(req), .req_data(req_data), .grant(grant), .done(done),
    .busy(busy), .clock_enable(ce), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  logic [N-1:0]   req1 = '0;
  logic [8*N-1:0] req_data1 = '0;
  logic [N-1:0]   grant1, done1;
  logic           busy1, ce1, tx_valid1;
  logic [7:0]     tx_data1;
  logic           tx_ready1 = 1'b0;

  uart_tx_scheduler #(.N_REQ(N), .BAUD_DIV(1)) dut1 (
    .CLKIN(clk), .RESET(rst), .req(req1), .req_data(req_data1), .grant(grant1), .done(done1),
    .busy(busy1), .clock_enable(ce1), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural transmitter: never reset, shifts the live tx_data so an unstable byte shows up on the line.
  logic       act = 1'b0;
  logic       tx_line = 1'b1;
  logic       fr_end = 1'b0;
  logic [3:0] idx = 4'd0;
  logic [9:0] fr_bits = '0;
  always @(posedge clk) begin
    fr_end <= 1'b0;
    if (ce) begin
      if (!act) begin
        if (tx_valid) begin
          act      <= 1'b1;
          tx_ready <= 1'b1;
          idx      <= 4'd0;
          tx_line  <= 1'b0;
        end
      end else begin
        fr_bits[idx] <= tx_line;
        if (idx == 4'd9) begin
          act      <= 1'b0;
          tx_ready <= 1'b0;
          fr_end   <= 1'b1;
        end else begin
          idx     <= idx + 4'd1;
          tx_line <= (idx == 4'd8) ? 1'b1 : tx_data[idx[2:0]];
        end
      end
    end
  end

  logic       act1 = 1'b0;
  logic [3:0] cnt1 = 4'd0;
  always @(posedge clk) begin
    if (ce1) begin
      if (!act1) begin
        if (tx_valid1) begin
          act1      <= 1'b1;
          cnt1      <= 4'd0;
          tx_ready1 <= 1'b1;
        end
      end else if (cnt1 == 4'd9) begin
        act1      <= 1'b0;
        tx_ready1 <= 1'b0;
      end else begin
        cnt1 <= cnt1 + 4'd1;
      end
    end
  end

  int         exp_grant[$];
  int         exp_done[$];
  logic [7:0] exp_byte[$];
  bit         drop_frame = 1'b0;

  task automatic expect_frame(input int g, input logic [7:0] b);
    exp_grant.push_back(g);
    exp_done.push_back(g);
    exp_byte.push_back(b);
  endtask

  // Monitor: pops the scoreboard on every grant, done and completed serial frame.
  bit         ready_prev = 1'b0;
  bit         hold_trk = 1'b0;
  int         hold_ticks = 0;
  int         flush_ticks = 0;
  logic [7:0] mb;
  int         mg;
  always @(negedge clk) begin
    if (rst) begin
      hold_trk    = 1'b0;
      flush_ticks = 0;
    end else begin
      if (grant != '0) begin
        chk("grant_onehot", 32'($onehot(grant)), 1);
        chk("grant_done_excl", 32'(done), 0);
        chk("grant_after_flush", 32'(flush_ticks >= 11), 1);
        if (exp_grant.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_grant: got %b, want none", grant);
        end else begin
          mg = exp_grant.pop_front();
          chk("grant_idx", 32'(grant), 32'(1) << mg);
        end
      end
      if (done != '0) begin
        if (exp_done.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got %b, want none", done);
        end else begin
          mg = exp_done.pop_front();
          chk("done_idx", 32'(done), 32'(1) << mg);
        end
        if (hold_trk) begin
          chk("ready_to_done_ticks", 32'(hold_ticks), 10);
          hold_trk = 1'b0;
        end
      end else if (hold_trk && ce) begin
        hold_ticks++;
      end else if (!hold_trk && tx_ready && !ready_prev) begin
        // The edge after this sample is where the scheduler sees ready; ticks count from there.
        hold_trk   = 1'b1;
        hold_ticks = 0;
      end
      if (ce && flush_ticks < 1000) flush_ticks++;
    end
    if (fr_end) begin
      if (drop_frame) begin
        drop_frame = 1'b0;
      end else if (exp_byte.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_frame: got %b, want none", fr_bits);
      end else begin
        mb = exp_byte.pop_front();
        chk("serial_frame", {22'd0, 1'b1, mb, 1'b0}, {22'd0, fr_bits});
      end
    end
    ready_prev = tx_ready;
  end

  task automatic wait_grant(input int bound);
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (grant != '0) return;
    end
    tests++; fails++;
    $display("FAIL wait_grant: got timeout after %0d cycles, want a grant", bound);
  endtask

  task automatic wait_done(input int bound);
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (done != '0) return;
    end
    tests++; fails++;
    $display("FAIL wait_done: got timeout after %0d cycles, want a done", bound);
  endtask

  task automatic wait_idle(input int bound);
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (!busy) return;
    end
    tests++; fails++;
    $display("FAIL wait_idle: got busy after %0d cycles, want idle", bound);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_ce"}, 32'(ce), 0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'h0000_00FF);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 0);
  endtask

  int rr_tab[4]  = '{1, 3, 1, 3};
  int all_tab[5] = '{0, 1, 2, 3, 0};

  initial begin
    bit all_one;
    int n;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;

    // BAUD_DIV=1: tick every cycle, ready-seen to done is ten cycles.
    all_one = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ce1 !== 1'b1) all_one = 1'b0;
    end
    chk("d1_ce_constant", 32'(all_one), 1);
    chk("d1_idle_after_flush", 32'(busy1), 0);
    req1[2] = 1'b1;
    req_data1[23:16] = 8'h81;
    @(negedge clk);
    chk("d1_grant", 32'(grant1), 32'h4);
    chk("d1_tx_data", 32'(tx_data1), 32'h81);
    req1 = '0;
    n = 0;
    while (tx_ready1 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("d1_ready_seen", 32'(tx_ready1), 1);
    n = 0;
    while (done1 == '0 && n < 50) begin @(negedge clk); n++; end
    chk("d1_done", 32'(done1), 32'h4);
    // n counts from the sample where ready first shows; the scheduler sees it one edge later.
    chk("d1_ready_to_done_cycles", 32'(n - 1), 10);

    // Single request 0xA5 from requester 0.
    wait_idle(300);
    expect_frame(0, 8'hA5);
    req_data[7:0] = 8'hA5;
    req[0] = 1'b1;
    @(negedge clk);
    chk("grant_latency", 32'(grant), 32'h1);
    chk("tx_valid_with_grant", 32'(tx_valid), 1);
    chk("tx_data_latched", 32'(tx_data), 32'hA5);
    req = '0;
    wait_done(300);
    wait_idle(50);

    // Fairness with req=1010 held.
    req_data[15:8]  = 8'h5C;
    req_data[31:24] = 8'hC3;
    for (int i = 0; i < 4; i++) expect_frame(rr_tab[i], (rr_tab[i] == 1) ? 8'h5C : 8'hC3);
    req = 4'b1010;
    for (int i = 0; i < 4; i++) wait_grant(200);
    req = '0;
    wait_done(200);
    wait_idle(50);

    // All four requesting; requester 0 stays up for a second turn.
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 5; i++) expect_frame(all_tab[i], 8'((all_tab[i] + 1) * 8'h11));
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant(200);
      if (i != 0) req[all_tab[i]] = 1'b0;
    end
    wait_done(200);
    wait_idle(50);

    // Withdrawal: requester 2 drops out during requester 1's frame.
    req_data[15:8]  = 8'h0F;
    req_data[23:16] = 8'hF0;
    req_data[31:24] = 8'h96;
    expect_frame(1, 8'h0F);
    expect_frame(3, 8'h96);
    req = 4'b1110;
    wait_grant(200);
    req[1] = 1'b0;
    req[2] = 1'b0;
    wait_grant(200);
    req[3] = 1'b0;
    wait_done(200);
    wait_idle(50);
    repeat (60) @(negedge clk);

    // Reset in the middle of HOLD.
    req_data[15:8] = 8'h5A;
    expect_frame(1, 8'h5A);
    req = 4'b0010;
    wait_grant(200);
    req = '0;
    n = 0;
    while (tx_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    exp_grant.delete();
    exp_done.delete();
    exp_byte.delete();
    drop_frame = 1'b1;
    req_data[23:16] = 8'h3C;
    expect_frame(2, 8'h3C);
    req = 4'b0100;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_grant(300);
    chk("line_idle_at_grant", 32'(tx_line), 1);
    req = '0;
    wait_done(200);
    wait_idle(50);
    repeat (10) @(negedge clk);

    chk("scoreboard_empty", 32'(exp_grant.size() + exp_done.size() + exp_byte.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: got no finish by 200us, want finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
